// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution for the femtorv32 EX stage: evaluates the branch condition
// from SUB flags, redirects the PC, sequences a two-cycle squash and counts transfers.
module branch_resolve_unit #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  input  logic         ex_branch,
  input  logic         ex_jump,
  input  logic [2:0]   ex_funct3,
  input  logic [n-1:0] ex_target,
  input  logic         zFlag,
  input  logic         sFlag,
  input  logic         cFlag,
  input  logic         vFlag,
  input  logic         stall,
  output logic         redirect,
  output logic [n-1:0] redirect_pc,
  output logic         flush_if_id,
  output logic         flush_id_ex,
  output logic         illegal_branch,
  output logic [31:0]  branch_count,
  output logic [31:0]  taken_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SQUASH   = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [n-1:0] r_redirect_pc;
  logic [31:0]  r_branch_count;
  logic [31:0]  r_taken_count;
  logic         r_illegal;

  logic w_cond;
  logic w_taken;
  logic w_illegal;
  logic w_accept;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_cond = 1'b0;
    case (ex_funct3)
      3'b000:  w_cond = zFlag;
      3'b001:  w_cond = ~zFlag;
      3'b100:  w_cond = sFlag ^ vFlag;
      3'b101:  w_cond = ~(sFlag ^ vFlag);
      3'b110:  w_cond = ~cFlag;
      3'b111:  w_cond = cFlag;
      default: w_cond = 1'b0;
    endcase
  end

  // Jumps win over branches and never look at funct3.
  assign w_taken   = ex_jump | (ex_branch & w_cond);
  assign w_illegal = ex_branch & ~ex_jump & (ex_funct3[2:1] == 2'b01);
  assign w_accept  = ex_valid & (ex_branch | ex_jump) & ~stall & (r_state == ST_IDLE);

  always_comb begin
    w_next_state = r_state;
    if (!stall) begin
      case (r_state)
        ST_IDLE:     if (w_accept && w_taken) w_next_state = ST_REDIRECT;
        ST_REDIRECT: w_next_state = ST_SQUASH;
        ST_SQUASH:   w_next_state = ST_IDLE;
        default:     w_next_state = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_redirect_pc  <= '0;
      r_branch_count <= '0;
      r_taken_count  <= '0;
      r_illegal      <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_illegal <= w_accept & w_illegal;
      if (w_accept) begin
        r_branch_count <= r_branch_count + 32'd1;
        if (w_taken) begin
          r_taken_count <= r_taken_count + 32'd1;
          r_redirect_pc <= ex_target;
        end
      end
    end
  end

  // Flush outputs decode straight from the state so a stall simply holds them.
  assign redirect       = (r_state == ST_REDIRECT);
  assign flush_id_ex    = (r_state == ST_REDIRECT);
  assign flush_if_id    = (r_state != ST_IDLE);
  assign redirect_pc    = r_redirect_pc;
  assign illegal_branch = r_illegal;
  assign branch_count   = r_branch_count;
  assign taken_count    = r_taken_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed vectors covering conditions,
// squash sequencing, stalls, illegal funct3, counter wrap and asynchronous reset.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_jump;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_target;
  logic        zFlag, sFlag, cFlag, vFlag;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        illegal_branch;
  logic [31:0] branch_count;
  logic [31:0] taken_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_resolve_unit #(.n(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .ex_jump        (ex_jump),
    .ex_funct3      (ex_funct3),
    .ex_target      (ex_target),
    .zFlag          (zFlag),
    .sFlag          (sFlag),
    .cFlag          (cFlag),
    .vFlag          (vFlag),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .illegal_branch (illegal_branch),
    .branch_count   (branch_count),
    .taken_count    (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic jmp, input logic [2:0] f3,
                       input logic [31:0] tgt, input logic [3:0] zscv);
    ex_valid  = 1'b1;
    ex_branch = br;
    ex_jump   = jmp;
    ex_funct3 = f3;
    ex_target = tgt;
    {zFlag, sFlag, cFlag, vFlag} = zscv;
  endtask

  task automatic idle_in();
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
    ex_jump   = 1'b0;
    ex_funct3 = 3'b000;
    ex_target = '0;
    {zFlag, sFlag, cFlag, vFlag} = 4'b0000;
  endtask

  task automatic check_flow(input string tag, input logic rd, input logic fif, input logic fie);
    check({tag, ".redirect"}, {31'd0, redirect}, {31'd0, rd});
    check({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, fif});
    check({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, fie});
  endtask

  task automatic check_counts(input string tag, input logic [31:0] bc, input logic [31:0] tc);
    check({tag, ".branch_count"}, branch_count, bc);
    check({tag, ".taken_count"}, taken_count, tc);
  endtask

  initial begin
    rst   = 1'b0;
    stall = 1'b0;
    idle_in();
    #12;
    check_flow("reset", 1'b0, 1'b0, 1'b0);
    check("reset.redirect_pc", redirect_pc, 32'h0);
    check("reset.illegal", {31'd0, illegal_branch}, 32'd0);
    check_counts("reset", 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // BEQ, z=1: taken to 0x40, full T+1/T+2/T+3 sequence.
    drive(1'b1, 1'b0, 3'b000, 32'h40, 4'b1000);
    step();
    idle_in();
    check_flow("beq.t1", 1'b1, 1'b1, 1'b1);
    check("beq.t1.pc", redirect_pc, 32'h40);
    check_counts("beq.t1", 32'd1, 32'd1);
    step();
    check_flow("beq.t2", 1'b0, 1'b1, 1'b0);
    step();
    check_flow("beq.t3", 1'b0, 1'b0, 1'b0);

    // BLT with s=1,v=1 is not taken; BLTU with c=0 is taken.
    drive(1'b1, 1'b0, 3'b100, 32'h60, 4'b0101);
    step();
    check_flow("blt.nt", 1'b0, 1'b0, 1'b0);
    check_counts("blt.nt", 32'd2, 32'd1);
    drive(1'b1, 1'b0, 3'b110, 32'h80, 4'b0000);
    step();
    idle_in();
    check_flow("bltu.t1", 1'b1, 1'b1, 1'b1);
    check("bltu.pc", redirect_pc, 32'h80);
    check_counts("bltu", 32'd3, 32'd2);
    step();
    step();

    // JAL with funct3=011 and zero flags is taken and legal; the following BNE is squashed.
    drive(1'b0, 1'b1, 3'b011, 32'h100, 4'b0000);
    step();
    check_flow("jal.t1", 1'b1, 1'b1, 1'b1);
    check("jal.illegal", {31'd0, illegal_branch}, 32'd0);
    check_counts("jal", 32'd4, 32'd3);
    drive(1'b1, 1'b0, 3'b001, 32'h200, 4'b0000);
    step();
    idle_in();
    check_flow("jal.t2", 1'b0, 1'b1, 1'b0);
    check("jal.t2.illegal", {31'd0, illegal_branch}, 32'd0);
    step();
    check_flow("jal.t3", 1'b0, 1'b0, 1'b0);
    check("jal.t3.pc", redirect_pc, 32'h100);
    check_counts("bne.squashed", 32'd4, 32'd3);

    // funct3=010 branch: illegal pulse, counted, not taken.
    drive(1'b1, 1'b0, 3'b010, 32'h240, 4'b1111);
    step();
    idle_in();
    check("ill.pulse", {31'd0, illegal_branch}, 32'd1);
    check_flow("ill", 1'b0, 1'b0, 1'b0);
    check_counts("ill", 32'd5, 32'd3);
    step();
    check("ill.clear", {31'd0, illegal_branch}, 32'd0);

    // A branch presented while stalled in IDLE is not accepted.
    stall = 1'b1;
    drive(1'b1, 1'b0, 3'b000, 32'h280, 4'b1000);
    step();
    idle_in();
    stall = 1'b0;
    check_flow("stall.idle", 1'b0, 1'b0, 1'b0);
    check_counts("stall.idle", 32'd5, 32'd3);

    // Taken BGE, then stall for three edges in REDIRECT.
    drive(1'b1, 1'b0, 3'b101, 32'h300, 4'b0000);
    step();
    idle_in();
    check_flow("bge.t1", 1'b1, 1'b1, 1'b1);
    stall = 1'b1;
    drive(1'b1, 1'b0, 3'b000, 32'h340, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      step();
      check_flow($sformatf("bge.stall%0d", i), 1'b1, 1'b1, 1'b1);
    end
    stall = 1'b0;
    idle_in();
    check("bge.pc", redirect_pc, 32'h300);
    check_counts("bge.stall", 32'd6, 32'd4);
    step();
    check_flow("bge.squash", 1'b0, 1'b1, 1'b0);
    step();
    check_flow("bge.idle", 1'b0, 1'b0, 1'b0);
    check_counts("bge.done", 32'd6, 32'd4);

    // Counter wrap: preload branch_count to all ones, accept a not-taken BEQ.
    dut.r_branch_count = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 3'b000, 32'h380, 4'b0000);
    step();
    idle_in();
    check_counts("wrap", 32'd0, 32'd4);

    // Asynchronous reset in the middle of REDIRECT.
    drive(1'b0, 1'b1, 3'b000, 32'h400, 4'b0000);
    step();
    idle_in();
    check_flow("rstmid.pre", 1'b1, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_flow("rstmid", 1'b0, 1'b0, 1'b0);
    check("rstmid.pc", redirect_pc, 32'h0);
    check("rstmid.illegal", {31'd0, illegal_branch}, 32'd0);
    check_counts("rstmid", 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check_flow("rstmid.after", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Consumes the ALU flags (z, s, c, v) produced by a SUB of rs1 and rs2 in the EX stage and decides branch and jump outcomes for the femtorv32 pipeline. It registers the decision, drives a one-cycle PC redirect with the target address, and sequences a two-cycle squash of younger instructions. It also keeps wrap-around counters of resolved and taken control transfers for performance inspection.

## Interface
- n, 32, datapath/address width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_branch  in  1  instruction is a conditional branch (B-type)
- ex_jump  in  1  instruction is JAL/JALR (always taken)
- ex_funct3  in  3  branch condition code
- ex_target  in  n  computed target address
- zFlag, sFlag, cFlag, vFlag  in  1 each  ALU flags for rs1 − rs2 this cycle
- stall  in  1  pipeline freeze; block holds all state
- redirect  out  1  PC must load redirect_pc this cycle
- redirect_pc  out  n  target address
- flush_if_id  out  1  squash IF/ID register
- flush_id_ex  out  1  squash ID/EX register
- illegal_branch  out  1  one-cycle pulse: ex_branch with funct3 010/011
- branch_count  out  32  resolved branches+jumps, wraps
- taken_count  out  32  taken branches+jumps, wraps

## Operation
- Condition (ex_branch): 000 BEQ = z; 001 BNE = ~z; 100 BLT = s^v; 101 BGE = ~(s^v); 110 BLTU = ~c; 111 BGEU = c; 010/011 not taken, raise illegal_branch.
- ex_jump has priority over ex_branch; it is always taken and ignores funct3.
- Accept condition: ex_valid & (ex_branch | ex_jump) & ~stall & state == IDLE.
- FSM states:
  - IDLE: on accept, increment branch_count. If taken, also increment taken_count, latch ex_target into redirect_pc, and go to REDIRECT. If not taken, stay in IDLE.
  - REDIRECT: redirect = 1, flush_if_id = 1, flush_id_ex = 1. Go to SQUASH.
  - SQUASH: flush_if_id = 1 only, which kills the instruction fetched from the stale PC. Go to IDLE.
- In REDIRECT and SQUASH, ex_valid inputs belong to squashed instructions. They are ignored: no counting, no redirect, no illegal_branch.
- stall = 1 freezes the state, redirect_pc and both counters. Combinational outputs keep the values of the frozen state.
- illegal_branch is a registered pulse. It is asserted the cycle after an accept with ex_branch & ~ex_jump & funct3 ∈ {010, 011}. That instruction is counted in branch_count but not in taken_count.
- Counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0.

## Timing
- Reset (asynchronous, rst = 0): state = IDLE, redirect = 0, redirect_pc = 0, flush_if_id = 0, flush_id_ex = 0, illegal_branch = 0, branch_count = 0, taken_count = 0. Reset during REDIRECT or SQUASH aborts the sequence immediately.
- Latency: flags are sampled on edge T. redirect and both flushes are high in cycle T+1. flush_if_id alone is high in T+2. A new branch can be accepted at edge T+3.
- redirect is high for exactly one unstalled cycle per taken transfer.
- Stall during REDIRECT: redirect and the flushes stay high until the first unstalled edge, then the FSM advances.
- Back-to-back branches: a branch in EX at T+1 or T+2 is squashed and ignored by design. A branch at T+3 is accepted normally.
- Not-taken branches produce no output activity except the count increment, visible at T+1.

## Test plan
- BEQ with z=1, target 0x0000_0040, accepted at edge T → redirect = 1 and redirect_pc = 0x40 in T+1 with both flushes; flush_if_id only in T+2; idle in T+3; branch_count = 1, taken_count = 1.
- BLT with s=1, v=1 (not taken), then BLTU with c=0 (taken) → first: no redirect, branch_count = 1. Second: redirect next cycle, counts 2/1.
- JAL with funct3 = 011 and all flags 0 → taken, illegal_branch stays 0. BNE issued in the following cycle is ignored (counts unchanged by it).
- Branch with funct3 = 010 → illegal_branch pulses for one cycle, no redirect, branch_count increments, taken_count does not.
- Taken BGE with stall = 1 held for 3 cycles during REDIRECT → redirect held 4 cycles total, then SQUASH for 1 cycle. Counters increment only once.
- Preload branch_count = 0xFFFFFFFF via repeated accepts (or force) and accept one more branch → branch_count = 0. Separately, assert rst = 0 mid-REDIRECT → all outputs 0 immediately, without waiting for a clock edge.
